// File: rtl/active_pixel_queue_pkg.sv
// Shared image geometry, FSM state encoding and the lowest-set-bit helper
// used by the active pixel queue.
package active_pixel_queue_pkg;

    localparam int unsigned IMG_W      = 28;
    localparam int unsigned IMG_H      = 28;
    localparam int unsigned ADDR_W     = 10;
    localparam int unsigned FIFO_DEPTH = IMG_W * IMG_H;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned COL_W      = $clog2(IMG_W);
    localparam int unsigned ROW_W      = $clog2(IMG_H);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WROW,
        S_DONE,
        S_DRAIN
    } state_e;

    // Priority encoder: index of the lowest set bit, 0 when no bit is set.
    function automatic logic [COL_W-1:0] lowest_set(input logic [IMG_W-1:0] v);
        lowest_set = '0;
        for (int unsigned i = 0; i < IMG_W; i++) begin
            if (v[IMG_W-1-i]) begin
                lowest_set = COL_W'(IMG_W - 1 - i);
            end
        end
    endfunction

endpackage

// File: rtl/active_pixel_queue_pixel_addr_fifo.sv
// First-word-fall-through synchronous FIFO of pixel addresses with a
// non-power-of-two depth; pointers wrap explicitly at DEPTH-1.
module pixel_addr_fifo #(
    parameter int unsigned DEPTH = 784,
    parameter int unsigned W     = 10,
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush, doPop;

    always_comb begin
        doPush  = push && (count_q != CNT_W'(DEPTH));
        doPop   = pop && (count_q != '0);
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && count_q == CNT_W'(DEPTH)))
                else $error("pixel_addr_fifo: push while full");
        end
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = empty ? '0 : mem[rdPtr_q];

endmodule

// File: rtl/active_pixel_queue.sv
// Image input stage: accepts one binarized row per handshake, queues the
// linear address of every set pixel, then hands the queue to Layer 1.
module active_pixel_queue
    import active_pixel_queue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [IMG_W-1:0]  rowIn,
    input  logic              rowValid,
    output logic              rowReady,
    input  logic              dequeue,
    output logic [ADDR_W-1:0] queueOut,
    output logic              queueEmpty,
    output logic              inputsReady,
    output logic              emptyImage
);

    state_e             state_q, state_d;
    logic [IMG_W-1:0]   rowBuf_q, rowBuf_d;
    logic [ROW_W-1:0]   rowIdx_q, rowIdx_d;
    logic [ADDR_W-1:0]  rowBase_q, rowBase_d;

    logic [COL_W-1:0]   lowCol;
    logic [IMG_W-1:0]   rowRest;
    logic [ADDR_W-1:0]  pushAddr;
    logic               push, pop, accept;
    logic [CNT_W-1:0]   count;

    assign lowCol   = lowest_set(rowBuf_q);
    assign rowRest  = rowBuf_q & (rowBuf_q - 1'b1);
    assign pushAddr = rowBase_q + ADDR_W'(lowCol);
    assign accept   = rowValid && rowReady;
    assign push     = (state_q == S_SCAN) && (rowBuf_q != '0);
    assign pop      = (state_q == S_DRAIN) && dequeue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            rowBuf_q  <= '0;
            rowIdx_q  <= '0;
            rowBase_q <= '0;
        end else begin
            state_q   <= state_d;
            rowBuf_q  <= rowBuf_d;
            rowIdx_q  <= rowIdx_d;
            rowBase_q <= rowBase_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rowBuf_d  = rowBuf_q;
        rowIdx_d  = rowIdx_q;
        rowBase_d = rowBase_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rowBuf_d  = rowIn;
                    rowIdx_d  = '0;
                    rowBase_d = '0;
                    state_d   = S_SCAN;
                end
            end
            // The row closes in the same cycle its last set bit is pushed,
            // so a row costs popcount cycles (one cycle when empty).
            S_SCAN: begin
                rowBuf_d = rowRest;
                if (rowRest == '0) begin
                    if (rowIdx_q == ROW_W'(IMG_H - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        rowIdx_d  = rowIdx_q + 1'b1;
                        rowBase_d = rowBase_q + ADDR_W'(IMG_W);
                        state_d   = S_WROW;
                    end
                end
            end
            S_WROW: begin
                if (accept) begin
                    rowBuf_d = rowIn;
                    state_d  = S_SCAN;
                end
            end
            S_DONE: begin
                state_d = (count == '0) ? S_IDLE : S_DRAIN;
            end
            S_DRAIN: begin
                state_d = (count == '0) ? S_IDLE : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rowReady    = !reset && ((state_q == S_IDLE) || (state_q == S_WROW));
        inputsReady = (state_q == S_DRAIN);
        emptyImage  = (state_q == S_DONE) && (count == '0);
    end

    pixel_addr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ADDR_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (push),
        .pop   (pop),
        .din   (pushAddr),
        .dout  (queueOut),
        .empty (queueEmpty),
        .count (count)
    );

endmodule

// File: tb/tb_active_pixel_queue.sv
// Directed bench for active_pixel_queue: hand-computed address streams and
// handshake timing for empty, sparse, single-row, full and reset-interrupted images.
module tb_active_pixel_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [27:0] rowIn;
    logic        rowValid;
    logic        rowReady;
    logic        dequeue;
    logic [9:0]  queueOut;
    logic        queueEmpty;
    logic        inputsReady;
    logic        emptyImage;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned emptyPulses = 0;
    int unsigned readyCycles = 0;

    active_pixel_queue dut (
        .clk         (clk),
        .reset       (reset),
        .rowIn       (rowIn),
        .rowValid    (rowValid),
        .rowReady    (rowReady),
        .dequeue     (dequeue),
        .queueOut    (queueOut),
        .queueEmpty  (queueEmpty),
        .inputsReady (inputsReady),
        .emptyImage  (emptyImage)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (emptyImage === 1'b1) emptyPulses++;
        if (inputsReady === 1'b1) readyCycles++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
            end
    endtask

    // Called at a negedge; returns at the negedge after the row was accepted.
    task automatic send_row(input logic [27:0] r);
        int unsigned n = 0;
        while (rowReady !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("row_ready_wait", rowReady, 1);
        rowIn    = r;
        rowValid = 1'b1;
        @(negedge clk);
        rowValid = 1'b0;
        rowIn    = '0;
    endtask

    task automatic wait_ready_cycles(input string tag, input int unsigned exp);
        int unsigned n = 0;
        while (rowReady !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk(tag, n, exp);
    endtask

    task automatic drain(input int unsigned exp[$]);
        int unsigned n = 0;
        while (inputsReady !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("inputs_ready_wait", inputsReady, 1);
        foreach (exp[i]) begin
            chk("head_valid", queueEmpty, 0);
            chk("head_addr", queueOut, exp[i]);
            dequeue = 1'b1;
            @(negedge clk);
            dequeue = 1'b0;
        end
        chk("drain_empty", queueEmpty, 1);
        chk("drain_ready_hold", inputsReady, 1);
        dequeue = 1'b1;
        @(negedge clk);
        chk("drain_ready_drop", inputsReady, 0);
        chk("drain_back_idle", rowReady, 1);
        repeat (3) @(negedge clk);
        dequeue = 1'b0;
        chk("no_underflow_empty", queueEmpty, 1);
        chk("no_underflow_out", queueOut, 0);
    endtask

    initial begin
        int unsigned exp[$];

        reset    = 1'b1;
        rowIn    = '0;
        rowValid = 1'b0;
        dequeue  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rowReady", rowReady, 0);
        chk("rst_queueEmpty", queueEmpty, 1);
        chk("rst_queueOut", queueOut, 0);
        chk("rst_inputsReady", inputsReady, 0);
        chk("rst_emptyImage", emptyImage, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_rowReady", rowReady, 1);

        // All-zero image
        emptyPulses = 0;
        readyCycles = 0;
        for (int unsigned r = 0; r < 28; r++) begin
            send_row('0);
            if (r == 3) wait_ready_cycles("zero_row_cycles", 1);
        end
        repeat (5) @(negedge clk);
        chk("zero_img_pulse", emptyPulses, 1);
        chk("zero_img_no_ready", readyCycles, 0);
        chk("zero_img_idle", rowReady, 1);
        chk("zero_img_qempty", queueEmpty, 1);

        // Corners only; dequeue held high while loading must not pop
        dequeue = 1'b1;
        for (int unsigned r = 0; r < 28; r++) begin
            if (r == 27) dequeue = 1'b0;
            send_row(r == 0 ? 28'h0000001 : (r == 27 ? 28'h8000000 : 28'h0));
        end
        exp = '{0, 783};
        drain(exp);

        // Row 5 fully set
        for (int unsigned r = 0; r < 28; r++) begin
            send_row(r == 5 ? 28'hFFFFFFF : 28'h0);
            if (r == 5) wait_ready_cycles("row5_scan_cycles", 28);
            if (r == 6) wait_ready_cycles("row6_scan_cycles", 1);
        end
        exp = {};
        for (int unsigned a = 140; a <= 167; a++) exp.push_back(a);
        drain(exp);

        // Every pixel set
        for (int unsigned r = 0; r < 28; r++) send_row(28'hFFFFFFF);
        exp = {};
        for (int unsigned a = 0; a < 784; a++) exp.push_back(a);
        drain(exp);

        // Reset while row 10 is being scanned
        for (int unsigned r = 0; r < 10; r++) send_row(28'h0000001);
        send_row(28'hFFFFFFF);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_rowReady", rowReady, 0);
        chk("mid_rst_queueEmpty", queueEmpty, 1);
        chk("mid_rst_queueOut", queueOut, 0);
        chk("mid_rst_inputsReady", inputsReady, 0);
        chk("mid_rst_emptyImage", emptyImage, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_rowReady", rowReady, 1);
        chk("post_rst_queueEmpty", queueEmpty, 1);
        for (int unsigned r = 0; r < 28; r++) begin
            send_row(r == 0 ? 28'h0000001 : (r == 27 ? 28'h8000000 : 28'h0));
        end
        exp = '{0, 783};
        drain(exp);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
